node_port_arbiter: RTL and testbench
====================================

NODE_PORT_ARBITER -- requirements
Module: node_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 shiftInCLK  input  1  clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 shiftInLeftData / shiftInRightData / shiftInData  input  32 each  word offered by the left neighbour, right neighbour and local node.
REQ-005 shiftInLeftCS / shiftInRightCS / shiftInCS  input  1 each  one-cycle strobe qualifying the matching data word.
REQ-006 outReady  input  1  downstream accepts the presented word this cycle.
REQ-007 shiftOutData  output  32  granted word.
REQ-008 shiftOutCS  output  1  shiftOutData valid.
REQ-009 dataSource  output  2  origin of the presented word: 00 none, 01 left, 10 right, 11 self.
REQ-010 pendingMask  output  3  holding-register occupancy, bit2 = left, bit1 = right, bit0 = self.
REQ-011 overflowFlags  output  3  sticky per-port drop flags, same bit order as pendingMask.
REQ-012 dropCount  output  8  saturating total of dropped words.

Function
REQ-013 Each port SHALL own a one-word holding register and a pending bit.
- A high CS at an edge loads the word and sets pending.
REQ-014 Transfer rules:
- A transfer occurs at an edge where shiftOutCS and outReady are both high.
- A transfer clears the granted port's pending bit, unless that port's CS is high at the same edge.
- In that case the new word is loaded and pending stays 1.
REQ-015 Overflow handling:
- Trigger: a CS arrives while the port is pending and is not being transferred at that edge.
- The incoming word is dropped and the held word is kept.
- The port's overflowFlags bit is set.
- dropCount increments, saturating at 255.
REQ-016 When drops occur on several ports at one edge, dropCount SHALL add the number of drops, saturating at 255.
REQ-017 FSM states SHALL be IDLE and PRESENT.
- IDLE: shiftOutCS = 0, dataSource = 00.
- PRESENT: shiftOutCS = 1.
REQ-018 IDLE -> PRESENT:
- Occurs at the first edge where pendingMask, as registered before that edge, is non-zero.
- Minimum latency from CS edge to shiftOutCS high is one cycle.
REQ-019 In PRESENT with outReady low, shiftOutData and dataSource SHALL hold stable, and the grant SHALL NOT change.
REQ-020 On a transfer edge:
- If another port is pending (excluding words captured at that same edge), the FSM stays in PRESENT and loads the next grant, giving back-to-back output.
- Otherwise it returns to IDLE.
REQ-021 Arbitration SHALL be round-robin over left -> right -> self -> left.
- Search starts at the port after the last transferred port.
- After reset the search starts at left.
REQ-022 The round-robin pointer SHALL advance only on a transfer, never on grant or stall.
REQ-023 The outputs shiftOutData, shiftOutCS and dataSource SHALL be registered, with no combinational path from any input.
REQ-024 Simultaneous CS on all three ports with all registers empty SHALL capture all three words, and they SHALL drain in round-robin order over three transfers.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear all of the following:
- all pending bits and overflowFlags;
- dropCount and the FSM (to IDLE);
- shiftOutCS, dataSource = 00 and shiftOutData = 0;
- the round-robin pointer, to left.
REQ-026 Reset mid-PRESENT SHALL discard the held words, and no transfer SHALL be reported.
REQ-027 A CS sampled at the first edge after rst_n deasserts SHALL be captured normally.

Verification
REQ-028 The bench SHALL cover:
- Right = 42 with one-cycle CS, outReady = 1 -> next cycle shiftOutCS = 1, data 42, dataSource 10; then IDLE.
- Left = 73 and self = 89 strobed together, outReady = 1 -> 73/01 then 89/11 on consecutive cycles; pendingMask 101 -> 001 -> 000.
- Back-pressure: outReady = 0 for 5 cycles with right = 1 pending -> output held at 1/10; right = 2 strobed meanwhile -> dropped, overflowFlags = 010, dropCount = 1.
- Fairness: right = 500, left = 800 and self = 4 strobed at once after the last transfer came from left -> order 500, 4, 800.
- Reset mid-PRESENT with left pending -> shiftOutCS = 0, pendingMask = 000, dropCount = 0; a left = 7 strobe after release is granted with dataSource 01.
- Saturation: 300 forced drops -> dropCount = 255.

Source files
------------

// File: rtl/node_port_arbiter.sv
// -----------------------------------------------------------------------------
// node_port_arbiter
//
// Merges words from three sources (left neighbour, right neighbour, local node)
// onto a single output stream. Each source owns a one-word holding register
// and a pending bit. A two-state FSM (IDLE / PRESENT) presents one pending
// word at a time. Grants are round-robin in the order left -> right -> self.
//
// Words that arrive while their port is still occupied are dropped. Each drop
// sets a sticky per-port flag and is added to a saturating counter.
//
// Ports
//   shiftInCLK        in   1   clock, rising edge
//   rst_n             in   1   asynchronous active-low reset
//   shiftInLeftData   in  32   word from the left neighbour
//   shiftInRightData  in  32   word from the right neighbour
//   shiftInData       in  32   word from the local node
//   shiftInLeftCS     in   1   strobe qualifying shiftInLeftData
//   shiftInRightCS    in   1   strobe qualifying shiftInRightData
//   shiftInCS         in   1   strobe qualifying shiftInData
//   outReady          in   1   downstream accepts the presented word
//   shiftOutData      out 32   presented (granted) word, registered
//   shiftOutCS        out  1   shiftOutData valid, registered
//   dataSource        out  2   00 none, 01 left, 10 right, 11 self
//   pendingMask       out  3   holding-register occupancy {left, right, self}
//   overflowFlags     out  3   sticky drop flags {left, right, self}
//   dropCount         out  8   saturating count of dropped words
// -----------------------------------------------------------------------------
module node_port_arbiter (
  input  logic        shiftInCLK,
  input  logic        rst_n,
  input  logic [31:0] shiftInLeftData,
  input  logic [31:0] shiftInRightData,
  input  logic [31:0] shiftInData,
  input  logic        shiftInLeftCS,
  input  logic        shiftInRightCS,
  input  logic        shiftInCS,
  input  logic        outReady,
  output logic [31:0] shiftOutData,
  output logic        shiftOutCS,
  output logic [1:0]  dataSource,
  output logic [2:0]  pendingMask,
  output logic [2:0]  overflowFlags,
  output logic [7:0]  dropCount
);

  localparam int NPORT = 3;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  // Ports are indexed by their position in the round-robin sequence:
  // 0 = left, 1 = right, 2 = self. The dataSource code is then position + 1.
  logic [31:0]      in_data [NPORT];
  logic [NPORT-1:0] in_cs;

  logic [31:0]      hold_reg [NPORT];
  logic [NPORT-1:0] pend_reg, pend_next;
  logic [NPORT-1:0] ovf_reg;
  logic [NPORT-1:0] load_en, drop_en, xfer_hit;

  state_t      state_reg, state_next;
  logic [1:0]  src_reg, src_next;
  logic [31:0] data_reg, data_next;
  logic [1:0]  rr_reg, rr_next;
  logic [7:0]  drop_cnt_reg, drop_cnt_next;

  logic        transfer;
  logic [1:0]  grant_pos;
  logic [1:0]  after_grant;
  logic [1:0]  drop_num;
  logic [8:0]  drop_sum;
  logic [2:0]  pick_idle, pick_next;

  assign in_data[0] = shiftInLeftData;
  assign in_data[1] = shiftInRightData;
  assign in_data[2] = shiftInData;
  assign in_cs      = {shiftInCS, shiftInRightCS, shiftInLeftCS};

  // A transfer happens when a word is presented and downstream takes it.
  assign transfer    = (state_reg == PRESENT) && outReady;
  assign grant_pos   = src_reg - 2'd1;
  assign after_grant = (grant_pos == 2'd2) ? 2'd0 : grant_pos + 2'd1;

  // ---------------------------------------------------------------------------
  // Per-port capture / drop decisions
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NPORT; gi++) begin : gen_port
    assign xfer_hit[gi] = transfer && (src_reg == 2'(gi + 1));
    // The port can take a new word if it is empty, or if the held word
    // leaves through the output at this same edge.
    assign load_en[gi]  = in_cs[gi] && (!pend_reg[gi] || xfer_hit[gi]);
    assign drop_en[gi]  = in_cs[gi] && pend_reg[gi] && !xfer_hit[gi];
    assign pend_next[gi] = load_en[gi] ? 1'b1 :
                           (xfer_hit[gi] ? 1'b0 : pend_reg[gi]);
  end

  // Up to three drops can occur in one cycle; add them all, then saturate.
  assign drop_num      = 2'(drop_en[0]) + 2'(drop_en[1]) + 2'(drop_en[2]);
  assign drop_sum      = {1'b0, drop_cnt_reg} + {7'd0, drop_num};
  assign drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // ---------------------------------------------------------------------------
  // Round-robin search: first set bit of req, starting at position start and
  // wrapping. Returns {found, position}.
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] p;
    res = 3'b000;
    p   = start;
    for (int k = 0; k < NPORT; k++) begin
      if (!res[2] && req[p]) res = {1'b1, p};
      p = (p == 2'd2) ? 2'd0 : p + 2'd1;
    end
    return res;
  endfunction

  // When entering PRESENT from IDLE, search from the stored pointer.
  // On a transfer, search from the port after the one just served. Only
  // words already pending before this edge are candidates; a word captured
  // at this same edge waits for the next edge.
  assign pick_idle = rr_pick(pend_reg, rr_reg);
  assign pick_next = rr_pick(pend_reg & ~xfer_hit, after_grant);

  // ---------------------------------------------------------------------------
  // FSM next-state / output-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    data_next  = data_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_idle[2]) begin
          state_next = PRESENT;
          src_next   = pick_idle[1:0] + 2'd1;
          data_next  = hold_reg[pick_idle[1:0]];
        end
      end
      PRESENT: begin
        // With outReady low, everything holds and the grant stays fixed.
        if (transfer) begin
          rr_next = after_grant;
          if (pick_next[2]) begin
            src_next  = pick_next[1:0] + 2'd1;
            data_next = hold_reg[pick_next[1:0]];
          end else begin
            state_next = IDLE;
            src_next   = 2'b00;
          end
        end
      end
      default: begin
        state_next = IDLE;
        src_next   = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge shiftInCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      src_reg      <= 2'b00;
      data_reg     <= 32'd0;
      rr_reg       <= 2'd0;
      pend_reg     <= '0;
      ovf_reg      <= '0;
      drop_cnt_reg <= 8'd0;
      for (int i = 0; i < NPORT; i++) hold_reg[i] <= 32'd0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      data_reg     <= data_next;
      rr_reg       <= rr_next;
      pend_reg     <= pend_next;
      ovf_reg      <= ovf_reg | drop_en;
      drop_cnt_reg <= drop_cnt_next;
      for (int i = 0; i < NPORT; i++) begin
        if (load_en[i]) hold_reg[i] <= in_data[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all are straight from flops. Status vectors are reordered so
  // that left is bit 2 and self is bit 0.
  // ---------------------------------------------------------------------------
  assign shiftOutCS    = (state_reg == PRESENT);
  assign shiftOutData  = data_reg;
  assign dataSource    = src_reg;
  assign pendingMask   = {pend_reg[0], pend_reg[1], pend_reg[2]};
  assign overflowFlags = {ovf_reg[0], ovf_reg[1], ovf_reg[2]};
  assign dropCount     = drop_cnt_reg;

endmodule

// File: tb/tb_node_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_node_port_arbiter
//
// Directed scenarios for node_port_arbiter with hand-computed expectations.
// Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_node_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] l_data, r_data, s_data;
  logic        l_cs, r_cs, s_cs;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_cs;
  logic [1:0]  data_src;
  logic [2:0]  pend_mask;
  logic [2:0]  ovf_flags;
  logic [7:0]  drop_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  node_port_arbiter dut (
    .shiftInCLK       (clk),
    .rst_n            (rst_n),
    .shiftInLeftData  (l_data),
    .shiftInRightData (r_data),
    .shiftInData      (s_data),
    .shiftInLeftCS    (l_cs),
    .shiftInRightCS   (r_cs),
    .shiftInCS        (s_cs),
    .outReady         (out_ready),
    .shiftOutData     (out_data),
    .shiftOutCS       (out_cs),
    .dataSource       (data_src),
    .pendingMask      (pend_mask),
    .overflowFlags    (ovf_flags),
    .dropCount        (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cs();
    l_cs = 1'b0;
    r_cs = 1'b0;
    s_cs = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_cs();
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presented word: valid, data and source together.
  task automatic chk_out(input string tag, input logic cs,
                         input logic [31:0] d, input logic [1:0] src);
    chk({tag, ".cs"}, 32'(out_cs), 32'(cs));
    if (cs) chk({tag, ".data"}, out_data, d);
    chk({tag, ".src"}, 32'(data_src), 32'(src));
  endtask

  initial begin
    l_data = 0; r_data = 0; s_data = 0;
    clear_cs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    // Reset state
    chk("rst.cs",   32'(out_cs), 0);
    chk("rst.src",  32'(data_src), 0);
    chk("rst.data", out_data, 0);
    chk("rst.pend", 32'(pend_mask), 0);
    chk("rst.ovf",  32'(ovf_flags), 0);
    chk("rst.drop", 32'(drop_cnt), 0);
    do_reset();

    // ---- Scenario 1: single right word -----------------------------------
    out_ready = 1'b1;
    r_data = 42; r_cs = 1'b1;
    tick();
    clear_cs();
    chk("s1.pend0", 32'(pend_mask), 3'b010);
    chk("s1.idle0", 32'(out_cs), 0);
    tick();
    chk_out("s1.pres", 1'b1, 42, 2'b10);
    tick();
    chk_out("s1.done", 1'b0, 0, 2'b00);
    chk("s1.pend1", 32'(pend_mask), 0);

    // ---- Scenario 2: left + self together --------------------------------
    do_reset();
    out_ready = 1'b1;
    l_data = 73; s_data = 89; l_cs = 1'b1; s_cs = 1'b1;
    tick();
    clear_cs();
    chk("s2.pendA", 32'(pend_mask), 3'b101);
    tick();
    chk_out("s2.first", 1'b1, 73, 2'b01);
    chk("s2.pendB", 32'(pend_mask), 3'b101);
    tick();
    chk_out("s2.second", 1'b1, 89, 2'b11);
    chk("s2.pendC", 32'(pend_mask), 3'b001);
    tick();
    chk_out("s2.done", 1'b0, 0, 2'b00);
    chk("s2.pendD", 32'(pend_mask), 3'b000);

    // ---- Scenario 3: back-pressure and overflow --------------------------
    do_reset();
    out_ready = 1'b0;
    r_data = 1; r_cs = 1'b1;
    tick();
    clear_cs();
    tick();
    chk_out("s3.stall0", 1'b1, 1, 2'b10);
    r_data = 2; r_cs = 1'b1;
    tick();
    clear_cs();
    chk_out("s3.stall1", 1'b1, 1, 2'b10);
    chk("s3.ovf", 32'(ovf_flags), 3'b010);
    chk("s3.drop", 32'(drop_cnt), 1);
    for (int i = 0; i < 3; i++) tick();
    chk_out("s3.stall4", 1'b1, 1, 2'b10);
    out_ready = 1'b1;
    tick();
    chk_out("s3.done", 1'b0, 0, 2'b00);
    chk("s3.pend", 32'(pend_mask), 0);
    chk("s3.ovfsticky", 32'(ovf_flags), 3'b010);

    // ---- Scenario 4: fairness after a left transfer ----------------------
    do_reset();
    out_ready = 1'b1;
    l_data = 11; l_cs = 1'b1;
    tick();
    clear_cs();
    tick();
    chk_out("s4.warm", 1'b1, 11, 2'b01);
    tick();
    chk("s4.idle", 32'(out_cs), 0);
    l_data = 800; r_data = 500; s_data = 4;
    l_cs = 1'b1; r_cs = 1'b1; s_cs = 1'b1;
    tick();
    clear_cs();
    chk("s4.pend", 32'(pend_mask), 3'b111);
    tick();
    chk_out("s4.g1", 1'b1, 500, 2'b10);
    tick();
    chk_out("s4.g2", 1'b1, 4, 2'b11);
    tick();
    chk_out("s4.g3", 1'b1, 800, 2'b01);
    tick();
    chk_out("s4.done", 1'b0, 0, 2'b00);

    // ---- Scenario 5: reset in PRESENT ------------------------------------
    do_reset();
    out_ready = 1'b0;
    l_data = 5; l_cs = 1'b1;
    tick();
    clear_cs();
    tick();
    chk_out("s5.pres", 1'b1, 5, 2'b01);
    l_data = 6; l_cs = 1'b1;
    tick();
    clear_cs();
    chk("s5.dropA", 32'(drop_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5.rst.cs",   32'(out_cs), 0);
    chk("s5.rst.src",  32'(data_src), 0);
    chk("s5.rst.data", out_data, 0);
    chk("s5.rst.pend", 32'(pend_mask), 0);
    chk("s5.rst.ovf",  32'(ovf_flags), 0);
    chk("s5.rst.drop", 32'(drop_cnt), 0);
    tick();
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    l_data = 7; l_cs = 1'b1;
    tick();
    clear_cs();
    chk("s5.cap", 32'(pend_mask), 3'b100);
    tick();
    chk_out("s5.g", 1'b1, 7, 2'b01);

    // ---- Scenario 6: multi-port drops and saturation ---------------------
    do_reset();
    out_ready = 1'b0;
    l_data = 100; r_data = 200; s_data = 300;
    l_cs = 1'b1; r_cs = 1'b1; s_cs = 1'b1;
    tick();
    chk("s6.fill", 32'(drop_cnt), 0);
    tick();
    chk("s6.triple", 32'(drop_cnt), 3);
    chk("s6.ovf", 32'(ovf_flags), 3'b111);
    for (int i = 0; i < 99; i++) tick();
    clear_cs();
    chk("s6.sat", 32'(drop_cnt), 255);
    chk_out("s6.hold", 1'b1, 100, 2'b01);
    tick();
    chk("s6.satkeep", 32'(drop_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
